// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video bank RAM arbiter for CRTC fetch, Z80 and cassette loader
// Video always wins its strobe cycle; the loader outranks the CPU until the CPU has lost STARVE_MAX times.
module vram_arbiter #(
    parameter int AW         = 14,
    parameter int STARVE_MAX = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_vid_req,
    input  logic [AW-1:0] i_vid_addr,
    output logic [7:0]    o_vid_data,
    output logic          o_vid_valid,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_addr,
    input  logic [7:0]    i_cpu_din,
    output logic [7:0]    o_cpu_dout,
    output logic          o_cpu_ack,
    output logic          o_cpu_wait,
    input  logic          i_ldr_req,
    input  logic [AW-1:0] i_ldr_addr,
    input  logic [7:0]    i_ldr_din,
    output logic          o_ldr_ack,
    output logic          o_mem_ce,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [7:0]    o_mem_din,
    input  logic [7:0]    i_mem_dout
);

    localparam int            SW         = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

    typedef enum logic [2:0] {
        TAG_NONE,
        TAG_VID,
        TAG_CPU_RD,
        TAG_CPU_WR,
        TAG_LDR
    } tag_t;

    tag_t          r_tag;
    tag_t          w_grant;
    logic [SW-1:0] r_starve;
    logic [SW-1:0] w_starve_next;
    logic [AW-1:0] r_mem_addr;
    logic [7:0]    r_mem_din;
    logic [7:0]    r_cpu_dout;
    logic          w_cpu_elig;
    logic          w_ldr_elig;
    logic          w_cpu_ahead;
    logic          w_cpu_granted;
    logic [AW-1:0] w_mem_addr;
    logic [7:0]    w_mem_din;

    // A requester whose ack is in flight is locked out for one cycle.
    always_comb begin
        w_cpu_elig  = i_cpu_req && (r_tag != TAG_CPU_RD) && (r_tag != TAG_CPU_WR);
        w_ldr_elig  = i_ldr_req && (r_tag != TAG_LDR);
        w_cpu_ahead = (r_starve == STARVE_TOP);
        w_grant     = TAG_NONE;
        if (!reset) begin
            w_grant = TAG_NONE;
        end else if (i_vid_req) begin
            w_grant = TAG_VID;
        end else if (w_cpu_elig && (w_cpu_ahead || !w_ldr_elig)) begin
            w_grant = i_cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
        end else if (w_ldr_elig) begin
            w_grant = TAG_LDR;
        end
    end

    assign w_cpu_granted = (w_grant == TAG_CPU_RD) || (w_grant == TAG_CPU_WR);

    always_comb begin
        w_starve_next = r_starve;
        if (!i_cpu_req || w_cpu_granted) begin
            w_starve_next = '0;
        end else if (w_cpu_elig && (w_grant == TAG_LDR) && (r_starve != STARVE_TOP)) begin
            w_starve_next = r_starve + SW'(1);
        end
    end

    // Idle cycles replay the last address/data so the RAM pins stay quiet.
    always_comb begin
        w_mem_addr = r_mem_addr;
        w_mem_din  = r_mem_din;
        case (w_grant)
            TAG_VID:    w_mem_addr = i_vid_addr;
            TAG_CPU_RD: w_mem_addr = i_cpu_addr;
            TAG_CPU_WR: begin
                w_mem_addr = i_cpu_addr;
                w_mem_din  = i_cpu_din;
            end
            TAG_LDR: begin
                w_mem_addr = i_ldr_addr;
                w_mem_din  = i_ldr_din;
            end
            default: ;
        endcase
    end

    assign o_mem_ce   = (w_grant != TAG_NONE);
    assign o_mem_we   = (w_grant == TAG_CPU_WR) || (w_grant == TAG_LDR);
    assign o_mem_addr = w_mem_addr;
    assign o_mem_din  = w_mem_din;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_tag      <= TAG_NONE;
            r_starve   <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_cpu_dout <= '0;
        end else begin
            r_tag      <= w_grant;
            r_starve   <= w_starve_next;
            r_mem_addr <= w_mem_addr;
            r_mem_din  <= w_mem_din;
            if (r_tag == TAG_CPU_RD) begin
                r_cpu_dout <= i_mem_dout;
            end
        end
    end

    // Return stage: the registered tag says whose data/ack is on the RAM output this cycle.
    assign o_vid_valid = (r_tag == TAG_VID);
    assign o_vid_data  = o_vid_valid ? i_mem_dout : 8'h00;
    assign o_cpu_ack   = (r_tag == TAG_CPU_RD) || (r_tag == TAG_CPU_WR);
    assign o_cpu_dout  = (r_tag == TAG_CPU_RD) ? i_mem_dout : r_cpu_dout;
    assign o_ldr_ack   = (r_tag == TAG_LDR);
    assign o_cpu_wait  = reset && i_cpu_req && !o_cpu_ack;

endmodule
